// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data RAM between the CPU
// load/store path and the debug port; one access at a time, one-cycle strobes.
module data_mem_arbiter #(
    parameter int ADDRESS_BUS_WIDTH  = 10,
    parameter int DATA_BUS_WIDTH     = 64,
    parameter int NUM_DATA_ADDRESSES = 512
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    cpu_wdata,
    output logic                         cpu_ack,
    output logic                         cpu_err,
    output logic [DATA_BUS_WIDTH-1:0]    cpu_rdata,
    input  logic                         dbg_req,
    input  logic                         dbg_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] dbg_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    dbg_wdata,
    output logic                         dbg_ack,
    output logic                         dbg_err,
    output logic [DATA_BUS_WIDTH-1:0]    dbg_rdata,
    output logic                         mem_cs,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
    output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
    output logic                         busy
);

    localparam logic [ADDRESS_BUS_WIDTH-1:0] MAX_ADDR = ADDRESS_BUS_WIDTH'(NUM_DATA_ADDRESSES - 8);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Word accesses must be 8-byte aligned and lie entirely inside the RAM.
    function automatic logic addr_illegal(input logic [ADDRESS_BUS_WIDTH-1:0] a);
        addr_illegal = (a[2:0] != 3'b000) || (a > MAX_ADDR);
    endfunction

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_we;
    logic                           r_gnt_dbg;
    logic                           r_last_dbg;
    logic                           r_mem_cs;
    logic                           r_mem_read;
    logic                           r_mem_write;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_mem_addr;
    logic [DATA_BUS_WIDTH-1:0]      r_mem_wdata;
    logic                           r_cpu_ack;
    logic                           r_cpu_err;
    logic [DATA_BUS_WIDTH-1:0]      r_cpu_rdata;
    logic                           r_dbg_ack;
    logic                           r_dbg_err;
    logic [DATA_BUS_WIDTH-1:0]      r_dbg_rdata;
    logic                           r_busy;

    logic                           w_grant;
    logic                           w_gnt_dbg;
    logic                           w_sel_we;
    logic [ADDRESS_BUS_WIDTH-1:0]   w_sel_addr;
    logic [DATA_BUS_WIDTH-1:0]      w_sel_wdata;
    logic                           w_illegal;
    logic                           w_issue;
    logic                           w_enter_resp;
    logic                           w_resp_dbg;
    logic                           w_resp_err;

    // On contention the port that did not win last time gets the grant.
    assign w_grant      = (r_state == S_IDLE) && (cpu_req || dbg_req);
    assign w_gnt_dbg    = dbg_req && (!cpu_req || !r_last_dbg);
    assign w_sel_we     = w_gnt_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr   = w_gnt_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata  = w_gnt_dbg ? dbg_wdata : cpu_wdata;
    assign w_illegal    = addr_illegal(w_sel_addr);
    assign w_issue      = w_grant && !w_illegal;
    assign w_enter_resp = (w_next_state == S_RESP);
    assign w_resp_dbg   = (r_state == S_IDLE) ? w_gnt_dbg : r_gnt_dbg;
    assign w_resp_err   = (r_state == S_IDLE) && w_illegal;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (w_illegal) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_ISSUE;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Request latch and round-robin pointer, updated only on grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_gnt_dbg  <= 1'b0;
            r_last_dbg <= 1'b1;
        end else if (w_grant) begin
            r_we       <= w_sel_we;
            r_gnt_dbg  <= w_gnt_dbg;
            r_last_dbg <= w_gnt_dbg;
        end else begin
            r_we       <= r_we;
            r_gnt_dbg  <= r_gnt_dbg;
            r_last_dbg <= r_last_dbg;
        end
    end

    // Registered RAM strobes, acks, read data and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_cs    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {ADDRESS_BUS_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_BUS_WIDTH{1'b0}};
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= {DATA_BUS_WIDTH{1'b0}};
            r_dbg_ack   <= 1'b0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= {DATA_BUS_WIDTH{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_mem_cs    <= w_issue;
            r_mem_read  <= w_issue && !w_sel_we;
            r_mem_write <= w_issue && w_sel_we;
            // Address and write data hold between accesses.
            if (w_issue) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end else begin
                r_mem_addr  <= r_mem_addr;
                r_mem_wdata <= r_mem_wdata;
            end
            r_cpu_ack <= w_enter_resp && !w_resp_dbg;
            r_cpu_err <= w_enter_resp && !w_resp_dbg && w_resp_err;
            r_dbg_ack <= w_enter_resp && w_resp_dbg;
            r_dbg_err <= w_enter_resp && w_resp_dbg && w_resp_err;
            if (r_state == S_CAPTURE) begin
                if (r_gnt_dbg) begin
                    r_dbg_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end else begin
                r_cpu_rdata <= r_cpu_rdata;
                r_dbg_rdata <= r_dbg_rdata;
            end
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    assign mem_cs    = r_mem_cs;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_err   = r_dbg_err;
    assign dbg_rdata = r_dbg_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter: transaction-level reference model,
// a RAM with registered read data, and directed scenarios with literal checks.
module tb_data_mem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int NUM = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, cpu_err, dbg_ack, dbg_err;
    logic          mem_cs, mem_read, mem_write, busy;

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .NUM_DATA_ADDRESSES(NUM)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_cs(mem_cs), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        logic [7:0] b0;
        if (i == 4) b0 = 8'd27;
        else if (i == 6) b0 = 8'd0;
        else b0 = 8'(i * 13 + 5);
        return {32'hA5C3_E100 | 32'(i), 24'(i * 977), b0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM with registered read data
    logic [63:0] ram [0:63];
    logic [63:0] ram_q;
    bit          ram_loaded = 1'b0;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_cs) begin
            if (mem_write) ram[mem_addr[8:3]] <= mem_wdata;
            if (mem_read)  ram_q <= ram[mem_addr[8:3]];
        end
    end

    // Reference model: one transaction in flight, timing from the sample cycle.
    logic [63:0] model_mem [0:63];
    int          cyc = 0, idle_from = 0, c_prev;
    bit          m_last_dbg = 1'b1;
    bit          t_act = 1'b0, t_dbg, t_we, t_err;
    int          t_s, t_ack;
    logic [9:0]  t_addr;
    logic [63:0] t_wd, t_rd;
    logic [63:0] m_cpu_rd, m_dbg_rd, m_mwd;
    logic [9:0]  m_maddr;
    bit          e_cs, e_ack, e_busy;

    always @(posedge clk) begin
        if (cyc == 0) for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
        c_prev = cyc;
        cyc    = cyc + 1;
        if (!reset_n) begin
            t_act = 1'b0; m_last_dbg = 1'b1; idle_from = cyc;
            m_cpu_rd = '0; m_dbg_rd = '0; m_maddr = '0; m_mwd = '0;
        end else if (c_prev >= idle_from && (cpu_req || dbg_req)) begin
            t_dbg      = (cpu_req && dbg_req) ? !m_last_dbg : dbg_req;
            m_last_dbg = t_dbg;
            t_act  = 1'b1;
            t_s    = c_prev;
            t_we   = t_dbg ? dbg_we : cpu_we;
            t_addr = t_dbg ? dbg_addr : cpu_addr;
            t_wd   = t_dbg ? dbg_wdata : cpu_wdata;
            t_err  = (int'(t_addr) % 8 != 0) || (int'(t_addr) > NUM - 8);
            if (t_err) t_ack = t_s + 1;
            else if (t_we) begin
                t_ack = t_s + 2;
                model_mem[int'(t_addr) / 8] = t_wd;
            end else begin
                t_ack = t_s + 3;
                t_rd  = model_mem[int'(t_addr) / 8];
            end
            idle_from = t_ack + 1;
        end
        #1;
        e_cs   = t_act && !t_err && (cyc == t_s + 1);
        e_ack  = t_act && (cyc == t_ack);
        e_busy = t_act && (cyc > t_s) && (cyc <= t_ack);
        if (e_cs) begin m_maddr = t_addr; m_mwd = t_wd; end
        if (e_ack && !t_err && !t_we) begin
            if (t_dbg) m_dbg_rd = t_rd; else m_cpu_rd = t_rd;
        end
        chk("cpu_ack",   64'(cpu_ack),   64'(e_ack && !t_dbg));
        chk("cpu_err",   64'(cpu_err),   64'(e_ack && !t_dbg && t_err));
        chk("cpu_rdata", cpu_rdata,      m_cpu_rd);
        chk("dbg_ack",   64'(dbg_ack),   64'(e_ack && t_dbg));
        chk("dbg_err",   64'(dbg_err),   64'(e_ack && t_dbg && t_err));
        chk("dbg_rdata", dbg_rdata,      m_dbg_rd);
        chk("mem_cs",    64'(mem_cs),    64'(e_cs));
        chk("mem_read",  64'(mem_read),  64'(e_cs && !t_we));
        chk("mem_write", 64'(mem_write), 64'(e_cs && t_we));
        chk("mem_addr",  64'(mem_addr),  64'(m_maddr));
        chk("mem_wdata", mem_wdata,      m_mwd);
        chk("busy",      64'(busy),      64'(e_busy));
    end

    task automatic set_port(input bit dbg, input bit rq, input bit we, input logic [9:0] a, input logic [63:0] wd);
        if (dbg) begin dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
        else     begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    endtask

    // One directed transaction with latency, strobe, error and data checks.
    task automatic xact(input bit dbg, input bit we, input logic [9:0] a, input logic [63:0] wd,
                        input int lat, input bit e_err, input bit chk_rd, input logic [63:0] e_rd, input string nm);
        int n = 0; int cs_cnt = 0; bit ack = 1'b0; logic [9:0] cs_addr = '0; bit cs_wr = 1'b0;
        @(negedge clk);
        set_port(dbg, 1'b1, we, a, wd);
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_cs) begin cs_cnt++; cs_addr = mem_addr; cs_wr = mem_write; end
            ack = dbg ? dbg_ack : cpu_ack;
        end
        if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_err"}, 64'(dbg ? dbg_err : cpu_err), 64'(e_err));
        chk({nm, "_cs_cnt"}, 64'(cs_cnt), 64'(e_err ? 0 : 1));
        if (!e_err) begin
            chk({nm, "_cs_addr"}, 64'(cs_addr), 64'(a));
            chk({nm, "_cs_wr"}, 64'(cs_wr), 64'(we));
        end
        if (chk_rd) chk({nm, "_rdata"}, dbg ? dbg_rdata : cpu_rdata, e_rd);
    endtask

    task automatic new_fields(input bit dbg);
        logic [9:0] a;
        a = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63) * 8);
        set_port(dbg, dbg ? dbg_req : cpu_req, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    endtask

    task automatic port_step(input bit dbg);
        bit rq, ak;
        rq = dbg ? dbg_req : cpu_req;
        ak = dbg ? dbg_ack : cpu_ack;
        if (rq && ak) begin
            if ($urandom_range(0, 3) == 0) new_fields(dbg);
            else if (dbg) dbg_req = 1'b0;
            else cpu_req = 1'b0;
        end else if (rq) begin
            if ($urandom_range(0, 3) == 0) new_fields(dbg);
        end else if ($urandom_range(0, 2) == 0) begin
            if (dbg) dbg_req = 1'b1; else cpu_req = 1'b1;
            new_fields(dbg);
        end
    endtask

    initial begin
        int k, n;
        bit         ord [4];
        logic [7:0] b0  [4];
        reset_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cs", 64'(mem_cs), 64'(0));
        chk("rst_cpu_rdata", cpu_rdata, 64'(0));
        reset_n = 1'b1;

        // Fairness: both ports load continuously from reset.
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 10'd32, '0);
        set_port(1'b1, 1'b1, 1'b0, 10'd48, '0);
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (cpu_ack && dbg_ack) chk("ack_overlap", 64'(1), 64'(0));
            if (cpu_ack) begin ord[k] = 1'b0; b0[k] = cpu_rdata[7:0]; k++; end
            else if (dbg_ack) begin ord[k] = 1'b1; b0[k] = dbg_rdata[7:0]; k++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("rr_count", 64'(k), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 64'(ord[i]), 64'(i % 2));
            chk("rr_byte0", 64'(b0[i]), (i % 2 == 0) ? 64'd27 : 64'd0);
        end

        xact(1'b0, 1'b1, 10'd16, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 1'b0, '0, "st16");
        xact(1'b0, 1'b0, 10'd16, '0, 3, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, "ld16");
        xact(1'b1, 1'b0, 10'd3, '0, 1, 1'b1, 1'b0, '0, "mis3");
        xact(1'b1, 1'b1, 10'(NUM - 4), 64'h55, 1, 1'b1, 1'b0, '0, "hi508");
        xact(1'b1, 1'b0, 10'(NUM - 8), '0, 3, 1'b0, 1'b1, init_word(63), "ld504");

        // Address changes after grant must not affect the access.
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 10'd24, '0);
        @(negedge clk);
        chk("latch_cs", 64'(mem_cs), 64'(1));
        chk("latch_addr", 64'(mem_addr), 64'd24);
        cpu_addr = 10'd40;
        n = 1;
        while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
        cpu_req = 1'b0;
        chk("latch_lat", 64'(n), 64'(3));
        chk("latch_rdata", cpu_rdata, init_word(3));

        // Reset during CAPTURE drops the load.
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 10'd40, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_cs", 64'({mem_cs, mem_read, mem_write}), 64'(0));
        chk("arst_maddr", 64'(mem_addr), 64'(0));
        chk("arst_mwdata", mem_wdata, 64'(0));
        chk("arst_acks", 64'({cpu_ack, cpu_err, dbg_ack, dbg_err}), 64'(0));
        chk("arst_cpu_rdata", cpu_rdata, 64'(0));
        chk("arst_dbg_rdata", dbg_rdata, 64'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        xact(1'b1, 1'b1, 10'd56, 64'hDEAD_BEEF_0BAD_F00D, 2, 1'b0, 1'b0, '0, "st56");
        xact(1'b1, 1'b0, 10'd56, '0, 3, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, "ld56");

        // Random traffic on both ports, checked cycle by cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            port_step(1'b0);
            port_step(1'b1);
        end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("end_idle", 64'(busy), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequences and shares the single-ported 64-bit byte-addressed data RAM between two requesters: the CPU load/store path and the debug/loader port.
- Arbitrates round-robin, latches the winning request, and drives the RAM chip-select and read/write strobes for exactly one cycle.
- Captures registered read data and returns a one-cycle ack, with an error flag for illegal addresses.
- Sits between the multicycle control unit (and debug port) and data_ram.

Parameters:
ADDRESS_BUS_WIDTH, 10, byte address width on all address ports
DATA_BUS_WIDTH, 64, data word width
NUM_DATA_ADDRESSES, 512, bytes in data RAM; legal word addresses are 0..NUM_DATA_ADDRESSES-8

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  ADDRESS_BUS_WIDTH  CPU byte address
cpu_wdata  input  DATA_BUS_WIDTH  CPU store data
cpu_ack  output  1  one-cycle completion pulse
cpu_err  output  1  valid with cpu_ack; 1 = illegal address, no access made
cpu_rdata  output  DATA_BUS_WIDTH  load data, valid with cpu_ack (load only)
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_err, dbg_rdata  same directions, widths and meanings for the debug port
mem_cs  output  1  RAM chip select
mem_read  output  1  RAM read strobe
mem_write  output  1  RAM write strobe
mem_addr  output  ADDRESS_BUS_WIDTH  RAM address
mem_wdata  output  DATA_BUS_WIDTH  RAM write data
mem_rdata  input  DATA_BUS_WIDTH  RAM registered read data
busy  output  1  high in every state except IDLE

Behaviour:
Reset (reset_n low, asynchronous):
- State goes to IDLE.
- All outputs are 0, including mem_* and both rdata buses.
- Latched request registers clear; the rr pointer is set to "last = DBG".
- Any in-flight transaction is dropped with no ack. After release, the first cycle is IDLE.

States: IDLE, ISSUE, CAPTURE, RESP.

IDLE:
- If no req, stay.
- If one req, grant it.
- If both req, grant the requester not equal to the rr pointer. The pointer updates to the granted requester on grant.
- On grant, latch we, addr, wdata and the grant id; later changes on the request inputs are ignored until ack.
- Address legality check on the latched value: addr[2:0] != 0 OR addr > NUM_DATA_ADDRESSES-8 is illegal.
  - Illegal: go to RESP with err=1; no mem_cs pulse.
  - Legal: go to ISSUE.

ISSUE (exactly 1 cycle):
- mem_cs=1, mem_addr and mem_wdata from latch, mem_read=~we, mem_write=we. Never both strobes high.
- Load goes to CAPTURE; store goes to RESP.

CAPTURE (1 cycle):
- mem_cs=0, strobes 0.
- At the closing edge, register mem_rdata into the granted port's rdata.
- Go to RESP.

RESP (1 cycle):
- Granted port's ack=1, and err as determined in IDLE. The other port's ack stays 0.
- Go to IDLE.
- rdata holds its last value until the next load completes on that port.

Latency, counted from the cycle req is sampled high in IDLE:
- Store ack: +2 cycles.
- Load ack: +3 cycles.
- Error ack: +1 cycle.

Outside ISSUE: mem_cs=0, mem_read=0, mem_write=0, and mem_addr and mem_wdata hold their last values.

Request handling:
- A req that is still high in the cycle after its ack is a new request, arbitrated in IDLE.
- Minimum spacing is 1 IDLE cycle between transactions.
- A req arriving while busy waits; it is not lost.

Fairness: with both ports requesting continuously, grants alternate CPU, DBG, CPU, …

Test Plan:
- Reset, then cpu_req=1, we=1, addr=16, wdata=64'h0123_4567_89AB_CDEF -> mem_cs/mem_write high for exactly 1 cycle with mem_addr=16; cpu_ack 2 cycles after sample, cpu_err=0.
- Then cpu_req=1, we=0, addr=16 -> mem_read pulse 1 cycle; cpu_ack 3 cycles after sample with cpu_rdata=64'h0123_4567_89AB_CDEF.
- cpu_req and dbg_req both held high from reset, loads at 32 and 48 -> grants alternate CPU, DBG, CPU, DBG; acks never overlap; each rdata matches preloaded RAM contents (27 and 0 in byte 0).
- dbg_req with addr=3 (misaligned), then addr=NUM_DATA_ADDRESSES-4 -> dbg_ack+dbg_err 1 cycle after sample, mem_cs stays 0 throughout.
- cpu load granted, cpu_addr changed to 40 during ISSUE -> access still uses the latched address, and the returned data matches it.
- Assert reset_n low during CAPTURE -> all outputs 0 immediately, no ack; after release a new dbg store completes normally with ack at +2.
